// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: 8x8 register file, src2 mux, and a single registered output slot.
// Optional write-through forwarding of a same-cycle writeback when OPF_BYPASS_EN is defined.
module operand_fetch_stage #(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 8,
    parameter int INSTR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        a,
    output logic [DATA_W-1:0]        b,
    output logic [3:0]               alu_control,
    output logic [$clog2(NREGS)-1:0] rd,
    output logic                     is_mem,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [DATA_W-1:0]        wb_data
);

    localparam int IDX_W = $clog2(NREGS);

    // Operand b comes from imm8 for these opcodes; LD/ST use it as an address offset.
    function automatic logic op_uses_imm(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b1001, 4'b1011,
            4'b1100, 4'b1101, 4'b1110, 4'b1111: op_uses_imm = 1'b1;
            default:                            op_uses_imm = 1'b0;
        endcase
    endfunction

    logic [DATA_W-1:0] regs [NREGS];

    logic [3:0]        op;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  rs_idx;
    logic [DATA_W-1:0] imm8;
    logic              imm_sel;
    logic              accept;
    logic              instr_unused;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;

    logic              vld_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [3:0]        ctrl_p0;
    logic [IDX_W-1:0]  rd_p0;
    logic              mem_p0;

    assign op           = instr[15:12];
    assign rd_idx       = instr[11:9];
    assign rs_idx       = instr[2:0];
    assign imm8         = instr[7:0];
    assign instr_unused = instr[8];
    assign imm_sel      = op_uses_imm(op);

    assign in_ready = !vld_p0 || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        src_a = regs[rd_idx];
        src_b = imm_sel ? imm8 : regs[rs_idx];
`ifdef OPF_BYPASS_EN
        if (wb_en && (wb_addr == rd_idx))
            src_a = wb_data;
        if (!imm_sel && wb_en && (wb_addr == rs_idx))
            src_b = wb_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Stage p0: operand capture into the output slot
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            a_p0    <= '0;
            b_p0    <= '0;
            ctrl_p0 <= '0;
            rd_p0   <= '0;
            mem_p0  <= 1'b0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            a_p0    <= src_a;
            b_p0    <= src_b;
            ctrl_p0 <= op;
            rd_p0   <= rd_idx;
            mem_p0  <= (op == 4'b0000) || (op == 4'b0001);
        end else if (out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign out_valid   = vld_p0;
    assign a           = a_p0;
    assign b           = b_p0;
    assign alu_control = ctrl_p0;
    assign rd          = rd_p0;
    assign is_mem      = mem_p0;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed steps with a scoreboard of expected output slots.
// Define OPF_BYPASS_EN for both RTL and bench to cover the forwarding build.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  alu_control;
    logic [2:0]  rd;
    logic        is_mem;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_data;

    operand_fetch_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .alu_control(alu_control), .rd(rd), .is_mem(is_mem),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] ctrl;
        logic [2:0] rd;
        logic       mem;
    } slot_t;

    slot_t      sq[$];
    logic [7:0] mregs [8];
    int         checks   = 0;
    int         errors   = 0;
    int         consumed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t predict(input logic [15:0] ins, input logic we,
                                      input logic [2:0] wa, input logic [7:0] wd);
        slot_t      s;
        logic [3:0] op;
        logic       imm;
        op  = ins[15:12];
        imm = op inside {4'h0, 4'h1, 4'h2, 4'hC, 4'hD, 4'hF, 4'hE, 4'h9, 4'hB};
        s.a    = mregs[ins[11:9]];
        s.b    = imm ? ins[7:0] : mregs[ins[2:0]];
`ifdef OPF_BYPASS_EN
        if (we && wa == ins[11:9]) s.a = wd;
        if (!imm && we && wa == ins[2:0]) s.b = wd;
`else
        if (we && wa == 3'd0 && wd == 8'h00) s.a = s.a;
`endif
        s.ctrl = op;
        s.rd   = ins[11:9];
        s.mem  = (op == 4'h0) || (op == 4'h1);
        return s;
    endfunction

    // One clock: observe at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        logic  consume;
        logic  accept;
        slot_t nxt;
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, sq.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (sq.size() == 0) || out_ready});
        if (sq.size() != 0) begin
            chk("a", {24'd0, a}, {24'd0, sq[0].a});
            chk("b", {24'd0, b}, {24'd0, sq[0].b});
            chk("alu_control", {28'd0, alu_control}, {28'd0, sq[0].ctrl});
            chk("rd", {29'd0, rd}, {29'd0, sq[0].rd});
            chk("is_mem", {31'd0, is_mem}, {31'd0, sq[0].mem});
        end
        if (out_valid === 1'b1 && out_ready) consumed++;
        consume = (sq.size() != 0) && out_ready;
        accept  = in_valid && ((sq.size() == 0) || out_ready);
        nxt     = predict(instr, wb_en, wb_addr, wb_data);
        @(posedge clk);
        if (reset) begin
            sq.delete();
            for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        end else begin
            if (consume) void'(sq.pop_front());
            if (accept) sq.push_back(nxt);
            if (wb_en) mregs[wb_addr] = wb_data;
        end
        #1;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [7:0] data);
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        for (int i = 0; i < 8; i++) mregs[i] = 8'hxx;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_a", {24'd0, a}, 32'd0);
        chk("rst_b", {24'd0, b}, 32'd0);
        chk("rst_ctrl", {28'd0, alu_control}, 32'd0);
        chk("rst_rd", {29'd0, rd}, 32'd0);
        chk("rst_is_mem", {31'd0, is_mem}, 32'd0);
        reset = 1'b0;

        // Register-register op reading written registers
        wb(3'd3, 8'h25);
        wb(3'd4, 8'h11);
        in_valid = 1'b1; instr = 16'b0100_011_0_00000100;
        tick();
        in_valid = 1'b0;
        chk("t1_a", {24'd0, a}, 32'h25);
        chk("t1_b", {24'd0, b}, 32'h11);
        chk("t1_ctrl", {28'd0, alu_control}, 32'h4);
        chk("t1_rd", {29'd0, rd}, 32'd3);
        tick();

        // Immediate op ignores R7; LD flags is_mem
        wb(3'd7, 8'hEE);
        in_valid = 1'b1; instr = 16'b1100_011_0_01111111;
        tick();
        chk("t2_b_imm", {24'd0, b}, 32'h7F);
        chk("t2_is_mem", {31'd0, is_mem}, 32'd0);
        instr = 16'b0000_010_0_00000101;
        tick();
        in_valid = 1'b0;
        chk("t2_ld_is_mem", {31'd0, is_mem}, 32'd1);
        chk("t2_ld_b", {24'd0, b}, 32'h05);
        tick();

        // Stall for three cycles with a pending instruction and a writeback in flight
        in_valid = 1'b1; instr = 16'b0011_001_0_00000011;
        tick();
        out_ready = 1'b0; instr = 16'b0101_100_0_00000011;
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h77;
        tick();
        wb_en = 1'b0;
        chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        chk("t3_hold_b", {24'd0, b}, 32'h25);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t3_next_a", {24'd0, a}, 32'h11);
        chk("t3_next_b", {24'd0, b}, 32'h77);
        tick();

        // Writeback to rd in the same cycle as the accept
        wb(3'd2, 8'h42);
        in_valid = 1'b1; instr = 16'b0100_010_0_00000011;
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h99;
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
`ifdef OPF_BYPASS_EN
        chk("t4_a_bypass", {24'd0, a}, 32'h99);
`else
        chk("t4_a_old", {24'd0, a}, 32'h42);
`endif
        tick();

        // Eight back-to-back instructions with concurrent writebacks
        consumed = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            instr = {(i % 2 == 0) ? 4'h4 : 4'hD, 3'(i), 1'b0, 5'(i * 3), 3'(7 - i)};
            wb_en = 1'b1; wb_addr = 3'(i + 1); wb_data = 8'(8'h30 + i);
            tick();
        end
        in_valid = 1'b0; wb_en = 1'b0;
        tick();
        chk("t5_outputs", consumed, 32'd8);
        tick();

        // Reset while the slot is held, with a writeback that must be ignored
        out_ready = 1'b0; in_valid = 1'b1; instr = 16'b0110_101_0_00000001;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 8'h55;
        tick();
        reset = 1'b0; wb_en = 1'b0;
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            instr = {4'h4, 3'(i), 1'b0, 5'd0, 3'(i)};
            tick();
            chk("t6_reg_a", {24'd0, a}, 32'd0);
            chk("t6_reg_b", {24'd0, b}, 32'd0);
        end
        in_valid = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
